// File: rtl/aes_tiled_round_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_tiled_round_seq                                                      |
// | Sequences one AES round through a 32-bit tiled AES unit: four SubBytes/  |
// | ShiftRows half-column steps, optional four MixColumns steps, AddRoundKey.|
// | Optional macro: AES_TILED_ROUND_SEQ_DECRYPT_EN (enables the decrypt path)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module aes_tiled_round_seq (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_dec,
  input  logic         in_last,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         req_valid,
  output logic         req_dec,
  output logic         req_op_sb,
  output logic         req_op_sbsr,
  output logic         req_op_mix,
  output logic         req_hi,
  output logic [31:0]  req_rs1,
  output logic [31:0]  req_rs2,
  input  logic         req_ready,
  input  logic [31:0]  req_rd
);

  localparam logic [2:0] c_LAST_SBSR_STEP = 3'd3;
  localparam logic [2:0] c_LAST_MIX_STEP  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_ADDKEY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_w [4];
  logic [31:0] r_t [4];
  logic [31:0] r_k [4];
  logic [2:0]  r_step;
  logic        r_last;
  logic        w_step_final;
  logic [31:0] w_rs1;
  logic [31:0] w_rs2;

  assign w_step_final = r_last ? (r_step == c_LAST_SBSR_STEP) : (r_step == c_LAST_MIX_STEP);

  // Steps 0-3 pair state words (W0,W1)/(W2,W3); steps 4-7 pair T words, swapped on odd steps.
  always_comb begin
    w_rs1 = '0;
    w_rs2 = '0;
    if (!r_step[2]) begin
      w_rs1 = r_w[{r_step[1], 1'b0}];
      w_rs2 = r_w[{r_step[1], 1'b1}];
    end else begin
      w_rs1 = r_t[r_step[1:0]];
      w_rs2 = r_t[r_step[1:0] ^ 2'b01];
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    req_valid   = 1'b0;
    req_op_sbsr = 1'b0;
    req_op_mix  = 1'b0;
    req_hi      = 1'b0;
    req_rs1     = '0;
    req_rs2     = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_valid   = 1'b1;
        req_op_sbsr = !r_step[2];
        req_op_mix  = r_step[2];
        req_hi      = !r_step[2] && r_step[0];
        req_rs1     = w_rs1;
        req_rs2     = w_rs2;
        if (req_ready && w_step_final) begin
          w_state_nxt = S_ADDKEY;
        end
      end
      S_ADDKEY: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign req_op_sb = 1'b0;
  assign out_state = {r_w[3], r_w[2], r_w[1], r_w[0]};

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      for (int i = 0; i < 4; i++) begin
        r_w[i] <= '0;
        r_t[i] <= '0;
        r_k[i] <= '0;
      end
      r_step <= '0;
      r_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 4; i++) begin
              r_w[i] <= in_state[32*i +: 32];
              r_k[i] <= in_key[32*i +: 32];
            end
            r_last <= in_last;
            r_step <= '0;
          end
        end
        S_ISSUE: begin
          if (req_ready) begin
            r_step <= r_step + 3'd1;
            if (!r_step[2]) begin
              r_t[r_step[1:0]] <= req_rd;
            end else begin
              r_w[r_step[1:0]] <= req_rd;
            end
            // Final round skips MixColumns: the ShiftRows result becomes the state directly.
            if (r_last && (r_step == c_LAST_SBSR_STEP)) begin
              for (int i = 0; i < 3; i++) begin
                r_w[i] <= r_t[i];
              end
              r_w[3] <= req_rd;
            end
          end
        end
        S_ADDKEY: begin
          for (int i = 0; i < 4; i++) begin
            r_w[i] <= r_w[i] ^ r_k[i];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef AES_TILED_ROUND_SEQ_DECRYPT_EN
  logic r_dec;

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_dec <= 1'b0;
    end else if ((r_state == S_IDLE) && in_valid) begin
      r_dec <= in_dec;
    end
  end

  assign req_dec = (r_state == S_ISSUE) && r_dec;
`else
  logic w_unused_dec;

  assign w_unused_dec = in_dec;
  assign req_dec      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_tiled_round_seq.sv
`default_nettype none
// Bench for aes_tiled_round_seq: stub tiled-AES responder, behavioural round
// model, request-sequence scoreboard and stall-stability monitor.
module tb_aes_tiled_round_seq;

  logic         g_clk = 1'b0;
  logic         g_reset;
  logic         in_valid, in_ready, in_dec, in_last;
  logic [127:0] in_state, in_key;
  logic         out_valid, out_ready;
  logic [127:0] out_state;
  logic         req_valid, req_dec, req_op_sb, req_op_sbsr, req_op_mix, req_hi;
  logic [31:0]  req_rs1, req_rs2, req_rd;
  logic         req_ready;

  typedef logic [68:0] req_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   rdy_mode = 0;
  int   stub_mode = 0;
  int   stab_viol = 0;
  int   stall_cycles = 0;
  req_t got_q[$];
  req_t exp_q[$];
  req_t cur_req, prev_req;
  logic prev_stall = 1'b0;

  localparam logic [127:0] VEC_W = {32'h88888888, 32'h44444444, 32'h22222222, 32'h11111111};
  localparam logic [127:0] VEC_K = {4{32'hA5A5A5A5}};

  aes_tiled_round_seq dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_dec(in_dec), .in_last(in_last),
    .in_state(in_state), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .req_valid(req_valid), .req_dec(req_dec), .req_op_sb(req_op_sb),
    .req_op_sbsr(req_op_sbsr), .req_op_mix(req_op_mix), .req_hi(req_hi),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_ready(req_ready), .req_rd(req_rd)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] stub(input bit sbsr, input bit hi, input logic [31:0] a,
                                       input logic [31:0] b, input int mode);
    if (mode == 0) return a ^ b;
    if (sbsr) return a ^ {b[23:0], b[31:24]} ^ (hi ? 32'h0F0F0F0F : 32'h0);
    return a + (b * 32'd3);
  endfunction

  always_comb req_rd = req_valid ? stub(req_op_sbsr, req_hi, req_rs1, req_rs2, stub_mode) : 32'hDEADBEEF;

  // req_ready changes just after each rising edge and holds through the next one.
  always @(posedge g_clk) begin
    cyc++;
    #2;
    case (rdy_mode)
      1:       req_ready = ($urandom_range(3) != 0);
      2:       req_ready = !(((cyc - hs_cyc) >= 2) && ((cyc - hs_cyc) <= 4));
      default: req_ready = 1'b1;
    endcase
  end

  always @(negedge g_clk) begin
    cur_req = {req_dec, req_op_sb, req_op_sbsr, req_op_mix, req_hi, req_rs1, req_rs2};
    if (g_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_cycles++;
        if (cur_req !== prev_req || req_valid !== 1'b1) stab_viol++;
      end
      if (req_valid && req_ready) got_q.push_back(cur_req);
      prev_stall = req_valid && !req_ready;
      prev_req   = cur_req;
    end
  end

  // Round model: SubBytes/ShiftRows halves into T, MixColumns pairs back into W, then key XOR.
  task automatic model(input logic [127:0] st, input logic [127:0] key, input bit last,
                       input bit dec, output logic [127:0] res);
    logic [31:0] w[4];
    logic [31:0] t[4];
    logic [31:0] a, b;
    bit          hi, dec_e;
`ifdef AES_TILED_ROUND_SEQ_DECRYPT_EN
    dec_e = dec;
`else
    dec_e = 1'b0;
`endif
    for (int i = 0; i < 4; i++) w[i] = st[32*i +: 32];
    for (int s = 0; s < 4; s++) begin
      a  = w[(s / 2) * 2];
      b  = w[(s / 2) * 2 + 1];
      hi = (s % 2 == 1);
      exp_q.push_back({dec_e, 1'b0, 1'b1, 1'b0, hi, a, b});
      t[s] = stub(1'b1, hi, a, b, stub_mode);
    end
    if (last) begin
      for (int i = 0; i < 4; i++) w[i] = t[i];
    end else begin
      for (int s = 0; s < 4; s++) begin
        a = t[s];
        b = t[s ^ 1];
        exp_q.push_back({dec_e, 1'b0, 1'b0, 1'b1, 1'b0, a, b});
        w[s] = stub(1'b0, 1'b0, a, b, stub_mode);
      end
    end
    for (int i = 0; i < 4; i++) res[32*i +: 32] = w[i] ^ key[32*i +: 32];
  endtask

  function automatic bit seq_eq();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_block(input logic [127:0] st, input logic [127:0] key, input bit last,
                           input bit dec, output int lat, output logic [127:0] outs);
    @(negedge g_clk);
    in_state = st; in_key = key; in_last = last; in_dec = dec; in_valid = 1'b1;
    @(posedge g_clk);
    #1;
    in_valid = 1'b0;
    hs_cyc = cyc;
    lat = 0;
    while (lat < 300) begin
      @(negedge g_clk);
      lat++;
      if (out_valid) break;
    end
    outs = out_state;
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge g_clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    g_reset = 1'b1;
    repeat (2) @(negedge g_clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    total++;
    if ({req_valid, req_dec, req_op_sb, req_op_sbsr, req_op_mix, req_hi, req_rs1, req_rs2} !== 70'd0) begin
      bad++; $display("FAIL reset_req got valid=%b rs1=%h rs2=%h want all zero", req_valid, req_rs1, req_rs2);
    end
    total++;
    if (out_state !== 128'd0) begin
      bad++; $display("FAIL reset_state got=%h want 0", out_state);
    end
    g_reset = 1'b0;
    @(negedge g_clk);
    total++;
    if (in_ready !== 1'b1 || req_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset in_ready=%b req_valid=%b want 1/0", in_ready, req_valid);
    end
  endtask

  task automatic test_vector();
    logic [127:0] exp, outs;
    int lat;
    got_q.delete(); exp_q.delete();
    model(VEC_W, VEC_K, 1'b0, 1'b0, exp);
    run_block(VEC_W, VEC_K, 1'b0, 1'b0, lat, outs);
    total++;
    if (outs !== VEC_K) begin bad++; $display("FAIL vec_out got=%h want=%h", outs, VEC_K); end
    total++;
    if (lat !== 10) begin bad++; $display("FAIL vec_lat got=%0d want=10", lat); end
    total++;
    if (got_q.size() !== 8 || !seq_eq()) begin
      bad++; $display("FAIL vec_reqs got_n=%0d want_n=%0d", got_q.size(), exp_q.size());
    end
    finish_out();
  endtask

  task automatic test_last();
    logic [127:0] exp, outs;
    logic [127:0] want;
    int lat;
    want = {32'hCCCCCCCC, 32'hCCCCCCCC, 32'h33333333, 32'h33333333};
    got_q.delete(); exp_q.delete();
    model(VEC_W, 128'd0, 1'b1, 1'b0, exp);
    run_block(VEC_W, 128'd0, 1'b1, 1'b0, lat, outs);
    total++;
    if (outs !== want) begin bad++; $display("FAIL last_out got=%h want=%h", outs, want); end
    total++;
    if (lat !== 6) begin bad++; $display("FAIL last_lat got=%0d want=6", lat); end
    total++;
    if (got_q.size() !== 4 || !seq_eq()) begin
      bad++; $display("FAIL last_reqs got_n=%0d want_n=4", got_q.size());
    end
    finish_out();
  endtask

  task automatic test_stall();
    logic [127:0] exp, outs;
    int lat;
    got_q.delete(); exp_q.delete();
    stab_viol = 0; stall_cycles = 0;
    rdy_mode = 2;
    model(VEC_W, VEC_K, 1'b0, 1'b0, exp);
    run_block(VEC_W, VEC_K, 1'b0, 1'b0, lat, outs);
    rdy_mode = 0;
    total++;
    if (outs !== exp) begin bad++; $display("FAIL stall_out got=%h want=%h", outs, exp); end
    total++;
    if (lat !== 13) begin bad++; $display("FAIL stall_lat got=%0d want=13", lat); end
    total++;
    if (stall_cycles !== 3 || stab_viol !== 0) begin
      bad++; $display("FAIL stall_stable stalls=%0d viol=%0d want 3/0", stall_cycles, stab_viol);
    end
    total++;
    if (!seq_eq()) begin bad++; $display("FAIL stall_reqs got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
    finish_out();
  endtask

  task automatic test_reset_mid();
    logic [127:0] exp, outs;
    int lat, n;
    @(negedge g_clk);
    in_state = VEC_W; in_key = VEC_K; in_last = 1'b0; in_dec = 1'b0; in_valid = 1'b1;
    @(posedge g_clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (n < 6) begin @(negedge g_clk); n++; end
    total++;
    if (req_valid !== 1'b1 || req_op_mix !== 1'b1) begin
      bad++; $display("FAIL rstmid_step5 valid=%b mix=%b want 1/1", req_valid, req_op_mix);
    end
    #1 g_reset = 1'b1;
    #1;
    total++;
    if (req_valid !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'd0) begin
      bad++; $display("FAIL rstmid_drop valid=%b in_ready=%b state=%h want 0/1/0", req_valid, in_ready, out_state);
    end
    #2 g_reset = 1'b0;
    got_q.delete();
    repeat (4) @(negedge g_clk);
    total++;
    if (got_q.size() !== 0 || req_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_noreissue reqs=%0d valid=%b want 0/0", got_q.size(), req_valid);
    end
    got_q.delete(); exp_q.delete();
    model(VEC_W, VEC_K, 1'b0, 1'b0, exp);
    run_block(VEC_W, VEC_K, 1'b0, 1'b0, lat, outs);
    total++;
    if (outs !== VEC_K || lat !== 10) begin
      bad++; $display("FAIL rstmid_next got=%h lat=%0d want=%h lat 10", outs, lat, VEC_K);
    end
    total++;
    if (!seq_eq()) begin bad++; $display("FAIL rstmid_reqs got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
    finish_out();
  endtask

  task automatic test_backpressure();
    logic [127:0] exp1, exp2, outs, st2, key2;
    int lat;
    st2  = {$urandom, $urandom, $urandom, $urandom};
    key2 = {$urandom, $urandom, $urandom, $urandom};
    got_q.delete(); exp_q.delete();
    model(VEC_W, VEC_K, 1'b0, 1'b0, exp1);
    run_block(VEC_W, VEC_K, 1'b0, 1'b0, lat, outs);
    in_state = st2; in_key = key2; in_last = 1'b0; in_dec = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_state !== exp1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d valid=%b state=%h in_ready=%b want 1/%h/0", k, out_valid, out_state, in_ready, exp1);
      end
      @(negedge g_clk);
    end
    total++;
    if (got_q.size() !== 8) begin bad++; $display("FAIL bp_noaccept reqs=%0d want 8", got_q.size()); end
    got_q.delete(); exp_q.delete();
    model(st2, key2, 1'b0, 1'b0, exp2);
    out_ready = 1'b1;
    @(posedge g_clk);
    #1 out_ready = 1'b0;
    @(negedge g_clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge g_clk);
    #1;
    in_valid = 1'b0;
    hs_cyc = cyc;
    lat = 0;
    while (lat < 300) begin
      @(negedge g_clk);
      lat++;
      if (out_valid) break;
    end
    total++;
    if (out_state !== exp2 || lat !== 10) begin
      bad++; $display("FAIL bp_second got=%h lat=%0d want=%h lat 10", out_state, lat, exp2);
    end
    total++;
    if (!seq_eq()) begin bad++; $display("FAIL bp_reqs got_n=%0d want_n=%0d", got_q.size(), exp_q.size()); end
    finish_out();
  endtask

  task automatic test_dec();
    logic [127:0] exp, outs;
    int lat;
    got_q.delete(); exp_q.delete();
    model(VEC_W, VEC_K, 1'b0, 1'b1, exp);
    run_block(VEC_W, VEC_K, 1'b0, 1'b1, lat, outs);
    total++;
    if (!seq_eq()) begin
      bad++; $display("FAIL dec_reqs got_first=%h want_first=%h", got_q.size() > 0 ? got_q[0] : '0, exp_q[0]);
    end
    total++;
    if (outs !== exp) begin bad++; $display("FAIL dec_out got=%h want=%h", outs, exp); end
    finish_out();
    in_dec = 1'b0;
  endtask

  task automatic test_random();
    logic [127:0] st, key, exp, outs;
    bit last, dec;
    int lat;
    stub_mode = 1;
    rdy_mode = 1;
    for (int n = 0; n < 20; n++) begin
      st   = {$urandom, $urandom, $urandom, $urandom};
      key  = {$urandom, $urandom, $urandom, $urandom};
      last = ($urandom_range(1) == 1);
      dec  = ($urandom_range(1) == 1);
      got_q.delete(); exp_q.delete();
      model(st, key, last, dec, exp);
      run_block(st, key, last, dec, lat, outs);
      total++;
      if (outs !== exp || lat >= 300 || lat < (last ? 6 : 10)) begin
        bad++; $display("FAIL rand%0d_out got=%h lat=%0d want=%h", n, outs, lat, exp);
      end
      total++;
      if (!seq_eq()) begin bad++; $display("FAIL rand%0d_reqs got_n=%0d want_n=%0d", n, got_q.size(), exp_q.size()); end
      finish_out();
    end
    rdy_mode = 0;
    stub_mode = 0;
  endtask

  initial begin
    g_reset = 1'b1; in_valid = 1'b0; in_dec = 1'b0; in_last = 1'b0;
    in_state = '0; in_key = '0; out_ready = 1'b0; req_ready = 1'b1;
    test_reset();
    test_vector();
    test_last();
    test_stall();
    test_reset_mid();
    test_backpressure();
    test_dec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_tiled_round_seq.md
AES_TILED_ROUND_SEQ -- requirements
Module: aes_tiled_round_seq

Interface
REQ-001 SHALL provide ports: g_clk  in  1  sole clock, rising edge.
REQ-002 SHALL provide: g_reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL provide: in_valid in 1; in_ready out 1; in_dec in 1 (0 encrypt, 1 decrypt); in_last in 1 (final round, no MixColumns).
REQ-004 SHALL provide: in_state in 128 (word Wi = bits 32i+31:32i); in_key in 128 (word Ki, same packing).
REQ-005 SHALL provide: out_valid out 1; out_ready in 1; out_state out 128, packed as in_state.
REQ-006 SHALL provide the request port to the tiled AES unit: req_valid out 1; req_dec out 1; req_op_sb out 1; req_op_sbsr out 1; req_op_mix out 1; req_hi out 1; req_rs1 out 32; req_rs2 out 32; req_ready in 1; req_rd in 32.

Function
REQ-007 SHALL implement states IDLE, ISSUE, ADDKEY, DONE, with a 3-bit step counter.
REQ-008 IDLE: in_ready=1; on in_valid, SHALL capture W0..W3, K0..K3, dec, last; step<=0; go ISSUE. in_ready SHALL be 0 in all other states.
REQ-009 ISSUE: req_valid=1, req_dec=captured dec, req_op_sb=0; operands/op taken from the step table; result req_rd written to destination on the cycle req_valid&&req_ready, then step increments.
REQ-010 Step table (op, hi, rs1, rs2 -> dest): 0 sbsr,0,W0,W1->T0; 1 sbsr,1,W0,W1->T1; 2 sbsr,0,W2,W3->T2; 3 sbsr,1,W2,W3->T3; 4 mix,-,T0,T1->W0; 5 mix,-,T1,T0->W1; 6 mix,-,T2,T3->W2; 7 mix,-,T3,T2->W3. In mix steps req_hi SHALL be 0.
REQ-011 When last=1, after step 3 completes SHALL copy Ti->Wi and go ADDKEY; steps 4-7 SHALL NOT be issued. When last=0, after step 7 go ADDKEY.
REQ-012 While req_valid=1 and req_ready=0, all req_* outputs SHALL remain stable.
REQ-013 ADDKEY: single cycle, Wi<=Wi^Ki for i=0..3; go DONE; req_valid=0.
REQ-014 DONE: out_valid=1, out_state={W3,W2,W1,W0} stable; on out_ready go IDLE. out_valid SHALL be 0 in all other states.
REQ-015 Latency with req_ready tied 1: in handshake at cycle 0; req_valid cycles 1-8 (1-4 if last); ADDKEY cycle 9 (5); out_valid from cycle 10 (6). Each req_ready-low cycle adds one cycle.
REQ-016 in_valid outside IDLE SHALL be ignored; a new block SHALL be accepted no earlier than the cycle after the out handshake.
REQ-017 req_rd SHALL be sampled only on req_valid&&req_ready; otherwise ignored.

Reset
REQ-018 On g_reset assertion, state SHALL become IDLE immediately (asynchronously), mid-operation included.
REQ-019 Reset values: in_ready=1, out_valid=0, out_state=0, req_valid=0, all other req_* outputs=0, W/T/K registers=0, step=0.
REQ-020 An in-flight request abandoned by reset SHALL NOT be reissued; its response SHALL be ignored.

Configuration
REQ-021 Macro AES_TILED_ROUND_SEQ_DECRYPT_EN SHALL control decrypt support.
REQ-022 Defined: in_dec captured and driven on req_dec per REQ-009.
REQ-023 Undefined: in_dec ignored, req_dec tied 0, no dec register; all other behaviour identical.

Verification
REQ-024 Stub responder rd=rs1^rs2, req_ready=1; last=0; W=0x11111111,0x22222222,0x44444444,0x88888888; K=0xA5A5A5A5 x4 -> out_state all words 0xA5A5A5A5; out_valid at cycle 10; ops/operands match REQ-010 in order.
REQ-025 Same stub and W, last=1, K=0 -> W0=W1=0x33333333, W2=W3=0xCCCCCCCC; exactly 4 requests; out_valid at cycle 6.
REQ-026 req_ready low 3 cycles during step 2 -> req_* stable for those cycles; result unchanged; out_valid at cycle 13.
REQ-027 g_reset pulsed during step 5 -> req_valid drops same cycle; in_ready=1 after reset; next block per REQ-024 gives correct result.
REQ-028 out_ready held 0 for 5 cycles with in_valid=1 -> out_state stable, in_ready 0, no second accept until cycle after out handshake.
REQ-029 in_dec=1: macro defined -> req_dec=1 on every request; macro undefined -> req_dec=0.
